bcd_counter_display: RTL and testbench

- Parametrised N-digit BCD up/down counter with a built-in prescaler and per-digit active-low 7-segment decode.
- Successor to the single-digit combinational BCD-to-7-segment decoder.
- Drives the board HEX displays directly: one static 7-bit group per digit, no multiplexing.
- Used for lab timers, event counters and scoreboards.

---
 rtl/bcd_counter_display_pkg.sv | 32 +++
 rtl/bcd_counter_display_digit_dec.sv | 29 ++
 rtl/bcd_counter_display.sv | 114 +++++++++++
 tb/tb_bcd_counter_display.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the BCD counter/display: segment patterns (active low,
// bit order {g,f,e,d,c,b,a}), segment bit indices and the BCD digit limit.
package bcd_counter_display_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Out-of-range load digits collapse to 0 so the counter only ever holds BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? 4'd0 : v;
  endfunction

endpackage

// File: rtl/bcd_counter_display_digit_dec.sv
// Single-digit BCD to active-low 7-segment decoder with a forced-blank input.
module bcd_digit_dec
  import bcd_counter_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaler and static per-digit 7-seg decode.
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50000000
)(
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic [7*DIGITS-1:0]   H,
  output logic                  Tick,
  output logic                  Tc
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]        pre_q, pre_d;
  logic [4*DIGITS-1:0]  q_q, q_d;
  logic                 tick_q, tick_d;
  logic                 tc_q, tc_d;
  logic                 carry;
  logic [3:0]           dig;
  logic [DIGITS-1:0]    blank;

  always_comb begin
    pre_d  = pre_q;
    q_d    = q_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    carry  = 1'b1;
    dig    = 4'd0;
    if (Load) begin
      pre_d = '0;
      for (int k = 0; k < DIGITS; k++) q_d[4*k +: 4] = bcd_clamp(D[4*k +: 4]);
    end else if (En) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        // carry doubles as borrow; surviving past the top digit means a wrap
        for (int k = 0; k < DIGITS; k++) begin
          dig = q_q[4*k +: 4];
          if (carry) begin
            if (Up) begin
              if (dig == BCD_MAX) dig = 4'd0;
              else begin
                dig   = dig + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (dig == 4'd0) dig = BCD_MAX;
              else begin
                dig   = dig - 4'd1;
                carry = 1'b0;
              end
            end
          end
          q_d[4*k +: 4] = dig;
        end
        tc_d = carry;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pre_q  <= '0;
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && (q_q[4*k +: 4] == 4'd0);
      blank[k]   = upper_zero;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_digit_dec u_dec (
      .bcd   (q_q[4*k +: 4]),
      .blank (blank[k]),
      .seg   (H[7*k +: 7])
    );
  end

  assign Q    = q_q;
  assign Tick = tick_q;
  assign Tc   = tc_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench for bcd_counter_display (DIGITS=2, PRESCALE=4) with an
// integer-valued reference model plus literal spot checks.
module tb_bcd_counter_display;

  localparam int NDIG = 2;
  localparam int PRE  = 4;
  localparam int MAXV = 100;

  logic              Clock = 1'b0;
  logic              Resetn, En, Up, Load;
  logic [4*NDIG-1:0] D;
  logic [4*NDIG-1:0] Q;
  logic [7*NDIG-1:0] H;
  logic              Tick, Tc;

  int checks = 0;
  int errors = 0;

  int m_val  = 0;
  int m_pre  = 0;
  bit m_tick = 0;
  bit m_tc   = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_counter_display #(.DIGITS(NDIG), .PRESCALE(PRE)) dut (
    .Clock (Clock), .Resetn (Resetn), .En (En), .Up (Up), .Load (Load),
    .D (D), .Q (Q), .H (H), .Tick (Tick), .Tc (Tc)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*NDIG-1:0] exp_q(input int v);
    logic [4*NDIG-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*NDIG-1:0] exp_h(input int v);
    logic [7*NDIG-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      r[7*k +: 7] = seg_tab[(v / p) % 10];
`ifdef BCD_LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) r[7*k +: 7] = 7'h7F;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_val(input logic [4*NDIG-1:0] d);
    int v, p, dg;
    v = 0;
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      dg = int'(d[4*k +: 4]);
      if (dg > 9) dg = 0;
      v = v + dg * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Reference model and per-cycle compare
  always @(posedge Clock) begin
    m_tick = 0;
    m_tc   = 0;
    if (!Resetn) begin
      m_val = 0;
      m_pre = 0;
    end else if (Load) begin
      m_val = load_val(D);
      m_pre = 0;
    end else if (En) begin
      if (m_pre == PRE - 1) begin
        m_pre  = 0;
        m_tick = 1;
        if (Up) begin
          m_tc  = (m_val == MAXV - 1);
          m_val = (m_val + 1) % MAXV;
        end else begin
          m_tc  = (m_val == 0);
          m_val = (m_val == 0) ? MAXV - 1 : m_val - 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    #1;
    chk("model_q",    32'(Q),    32'(exp_q(m_val)));
    chk("model_h",    32'(H),    32'(exp_h(m_val)));
    chk("model_tick", 32'(Tick), 32'(m_tick));
    chk("model_tc",   32'(Tc),   32'(m_tc));
  end

  task automatic wait_tick(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge Clock);
      #1;
      if (Tick) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [4*NDIG-1:0] v);
    @(negedge Clock);
    Load = 1'b1;
    D    = v;
    @(negedge Clock);
    Load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    Resetn = 1'b0; En = 1'b0; Up = 1'b1; Load = 1'b0; D = '0;
    repeat (2) @(negedge Clock);
    chk("reset_q",    32'(Q),    32'h00);
    chk("reset_tick", 32'(Tick), 32'd0);
    chk("reset_tc",   32'(Tc),   32'd0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    chk("reset_h", 32'(H), 32'({7'h7F, 7'h40}));
`else
    chk("reset_h", 32'(H), 32'({7'h40, 7'h40}));
`endif
    Resetn = 1'b1;
    En     = 1'b1;

    // First step exactly PRESCALE cycles after release
    cnt = 0;
    for (int i = 0; i < 10 && !Tick; i++) begin
      @(posedge Clock); #1; cnt++;
    end
    chk("first_step_latency", 32'(cnt), 32'd4);
    chk("first_step_q", 32'(Q), 32'h01);
    for (int i = 0; i < 9; i++) wait_tick(8);
    chk("count_10_q", 32'(Q), 32'h10);
    chk("count_10_h", 32'(H), 32'({7'h79, 7'h40}));

    // Up wrap 98 -> 99 -> 00
    load(8'h98);
    wait_tick(8);
    chk("up_99_q",  32'(Q),  32'h99);
    chk("up_99_tc", 32'(Tc), 32'd0);
    wait_tick(8);
    chk("up_wrap_q",  32'(Q),  32'h00);
    chk("up_wrap_tc", 32'(Tc), 32'd1);
`ifndef BCD_LEADING_ZERO_BLANK_EN
    chk("up_wrap_h",  32'(H),  32'({7'h40, 7'h40}));
`endif

    // Down wrap 00 -> 99 -> 98
    @(negedge Clock);
    Up = 1'b0;
    load(8'h00);
    wait_tick(8);
    chk("down_wrap_q",  32'(Q),  32'h99);
    chk("down_wrap_tc", 32'(Tc), 32'd1);
    chk("down_wrap_h",  32'(H),  32'({7'h10, 7'h10}));
    wait_tick(8);
    chk("down_98_q",  32'(Q),  32'h98);
    chk("down_98_tc", 32'(Tc), 32'd0);

    // Load coinciding with a step edge; digit 0 = C is forced to 0
    @(negedge Clock);
    repeat (3) @(negedge Clock);
    Load = 1'b1; D = 8'h3C; Up = 1'b1;
    @(negedge Clock);
    Load = 1'b0;
    chk("load_step_q",    32'(Q),    32'h30);
    chk("load_step_tick", 32'(Tick), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10 && !Tick; i++) begin
      @(posedge Clock); #1; cnt++;
    end
    chk("after_load_latency", 32'(cnt), 32'd4);
    chk("after_load_q", 32'(Q), 32'h31);

    // Freeze with En low, then async reset mid-prescale
    @(negedge Clock);
    En = 1'b0;
    repeat (10) @(negedge Clock);
    chk("frozen_q", 32'(Q), 32'h31);
    En = 1'b1;
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    #1;
    chk("async_rst_q",    32'(Q),    32'h00);
    chk("async_rst_tick", 32'(Tick), 32'd0);
    chk("async_rst_tc",   32'(Tc),   32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    wait_tick(8);
    chk("post_rst_q", 32'(Q), 32'h01);

    // Leading-zero behaviour on digit 1
    En = 1'b0;
    load(8'h07);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    chk("lz_07_h", 32'(H), 32'({7'h7F, 7'h78}));
`else
    chk("lz_07_h", 32'(H), 32'({7'h40, 7'h78}));
`endif
    load(8'h10);
    chk("lz_10_h", 32'(H), 32'({7'h79, 7'h40}));
    load(8'hF5);
    chk("clamp_hi_q", 32'(Q), 32'h05);

    repeat (3) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
